// File: rtl/cache_pkg.sv
// Shared types, default parameters and derived-width helpers for the cache fill engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_DATA_W          = 16;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_MEM_LATENCY     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Bytes in one memory word.
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // Width of the byte offset inside one cache block.
  function automatic int block_off_w(input int data_w, input int words);
    return $clog2(words * (data_w / 8));
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags cnt == LIMIT.
// Latency: count visible the cycle after an enabled increment.
// Backpressure: none; increments past LIMIT are dropped.
module fill_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             at_limit
);

  assign at_limit = (cnt == WIDTH'(LIMIT));

  // Clear wins over increment; the count holds once it reaches LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Block refill engine: on a miss, issues one read per cycle for the block and steers returns into the data array.
// Latency: busy for WORDS_PER_BLOCK+MEM_LATENCY cycles after the miss is accepted; tag written on the last return.
// Backpressure: none toward memory; the pipeline is stalled through fsm_busy, and misses during a fill are ignored.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int MEM_LATENCY     = DEF_MEM_LATENCY
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [DATA_W-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               write_tag_array
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int OFF_W = block_off_w(DATA_W, WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  // One extra bit so the counters can sit at WORDS_PER_BLOCK.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  // Reject parameter sets the address and counter arithmetic cannot handle.
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if ((WORDS_PER_BLOCK < 2) || ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0)) begin : g_bad_words
    $error("WORDS_PER_BLOCK must be a power of 2 and at least 2");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end

  fill_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic              issue_done;
  logic              recv_done;
  logic              in_fill;
  logic              last_word;

  // Counters are held clear while idle so a new fill always starts from word 0.
  fill_counter #(.WIDTH(CNT_W), .LIMIT(WORDS_PER_BLOCK)) u_issue_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!in_fill),
    .inc      (in_fill),
    .cnt      (issue_cnt),
    .at_limit (issue_done)
  );

  fill_counter #(.WIDTH(CNT_W), .LIMIT(WORDS_PER_BLOCK)) u_recv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!in_fill),
    .inc      (write_data_array),
    .cnt      (recv_cnt),
    .at_limit (recv_done)
  );

  assign in_fill        = (state == FILL);
  assign fsm_busy       = in_fill;
  assign mem_en         = in_fill && !issue_done;
  // base is block-aligned, so adding the word offset never carries out of the block.
  assign memory_address = mem_en ? (base + ADDR_W'(issue_cnt) * ADDR_W'(BYTES)) : '0;

  // Returns are only accepted during a fill and until the whole block has arrived.
  assign write_data_array = in_fill && memory_data_valid && !recv_done;
  assign fill_word        = write_data_array ? recv_cnt[IDX_W-1:0] : '0;
  assign fill_data        = memory_data;
  assign last_word        = write_data_array && (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
  assign write_tag_array  = last_word;

  // Fill control: latch the aligned block address on a miss, return to idle on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state <= FILL;
            base  <= miss_address & ~OFF_MASK;
          end
        end
        FILL: begin
          if (last_word) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: vector table, hand sequences and randomized traffic against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_fill_fsm;

  localparam int DW = 8;  // words per block, default instance
  localparam int DL = 4;  // memory latency, default instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        d_rst_n = 1'b0, d_miss = 1'b0, d_valid = 1'b0;
  logic [15:0] d_maddr = '0, d_data = '0;
  logic        d_busy, d_en, d_wr, d_tag;
  logic [15:0] d_addr, d_fdata;
  logic [2:0]  d_word;

  cache_fill_fsm u_dut (
    .clk(clk), .rst_n(d_rst_n), .miss_detected(d_miss), .miss_address(d_maddr),
    .memory_data_valid(d_valid), .memory_data(d_data), .fsm_busy(d_busy), .mem_en(d_en),
    .memory_address(d_addr), .write_data_array(d_wr), .fill_word(d_word),
    .fill_data(d_fdata), .write_tag_array(d_tag)
  );

  // Swept instance: 4 words of 32 bits, latency 1
  logic        s_rst_n = 1'b0, s_miss = 1'b0, s_valid = 1'b0;
  logic [15:0] s_maddr = '0;
  logic [31:0] s_data = '0;
  logic        s_busy, s_en, s_wr, s_tag;
  logic [15:0] s_addr;
  logic [31:0] s_fdata;
  logic [1:0]  s_word;

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(32), .WORDS_PER_BLOCK(4), .MEM_LATENCY(1)) u_sweep (
    .clk(clk), .rst_n(s_rst_n), .miss_detected(s_miss), .miss_address(s_maddr),
    .memory_data_valid(s_valid), .memory_data(s_data), .fsm_busy(s_busy), .mem_en(s_en),
    .memory_address(s_addr), .write_data_array(s_wr), .fill_word(s_word),
    .fill_data(s_fdata), .write_tag_array(s_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [15:0] data16(input logic [15:0] a);
    return {~a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction
  function automatic logic [31:0] data32(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Memory model for the default instance: a request seen in cycle t returns in cycle t+DL.
  bit          hist_v[64];
  logic [15:0] hist_a[64];

  // Reference model: a fill is just a start cycle and an aligned base; everything else is timeline arithmetic.
  int          cyc = 0;
  int          m_start = -1000;
  logic [15:0] m_base = '0;

  function automatic bit m_busy(input int t);
    return (t > m_start) && (t <= m_start + DW + DL);
  endfunction

  // One clock cycle on the default instance: drive inputs, feed memory returns, optionally check against the model.
  task automatic step(input bit miss, input logic [15:0] addr, input bit spur, input bit rst, input bit do_chk);
    int p, i, k;
    bit mv, e_busy, e_en, e_wr, e_tag;
    logic [15:0] e_addr;
    @(negedge clk);
    cyc++;
    p  = cyc - DL;
    mv = (p >= 0) && hist_v[p % 64];
    d_valid = mv | spur;
    d_data  = mv ? data16(hist_a[p % 64]) : 16'hDEAD;
    d_miss  = miss;
    d_maddr = addr;
    d_rst_n = !rst;
    if (rst) m_start = -1000;
    #1;
    hist_v[cyc % 64] = d_en;
    hist_a[cyc % 64] = d_addr;
    if (do_chk) begin
      e_busy = m_busy(cyc);
      i      = cyc - m_start - 1;
      k      = i - DL;
      e_en   = e_busy && (i < DW);
      e_addr = e_en ? 16'(m_base + i * 2) : 16'h0000;
      e_wr   = e_busy && (k >= 0) && (k < DW);
      e_tag  = e_busy && (cyc == m_start + DW + DL);
      chk($sformatf("model_busy c%0d", cyc), d_busy, e_busy);
      chk($sformatf("model_mem_en c%0d", cyc), d_en, e_en);
      chk($sformatf("model_addr c%0d", cyc), d_addr, e_addr);
      chk($sformatf("model_wr c%0d", cyc), d_wr, e_wr);
      chk($sformatf("model_tag c%0d", cyc), d_tag, e_tag);
      if (e_wr) begin
        chk($sformatf("model_word c%0d", cyc), d_word, k);
        chk($sformatf("model_data c%0d", cyc), d_fdata, data16(16'(m_base + k * 2)));
      end
    end
    if (!rst && miss && !m_busy(cyc)) begin
      m_start = cyc;
      m_base  = 16'(addr - addr % (DW * 2));
    end
  endtask

  typedef struct {
    bit          miss;
    logic [15:0] maddr;
    bit          spur;
    bit          busy;
    bit          en;
    logic [15:0] addr;
    bit          wr;
    int          word;
    bit          tag;
  } vec_t;

  vec_t vt[15];

  initial begin
    bit          prev_en;
    logic [15:0] prev_a;
    int          nb, na, nw, nt;

    // Basic fill at 0x1234, an ignored miss in cycle 3, a spurious return in idle at cycle 13.
    vt[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b0};
    vt[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 0, 1'b0};
    vt[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1232, 1'b0, 0, 1'b0};
    vt[3]  = '{1'b1, 16'h0F00, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 0, 1'b0};
    vt[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1236, 1'b0, 0, 1'b0};
    vt[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1238, 1'b1, 0, 1'b0};
    vt[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h123A, 1'b1, 1, 1'b0};
    vt[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h123C, 1'b1, 2, 1'b0};
    vt[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h123E, 1'b1, 3, 1'b0};
    vt[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 4, 1'b0};
    vt[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 5, 1'b0};
    vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 6, 1'b0};
    vt[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 7, 1'b1};
    vt[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b0};
    vt[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b0};

    // Reset state
    @(negedge clk);
    #1;
    chk("reset_busy", d_busy, 0);
    chk("reset_mem_en", d_en, 0);
    chk("reset_addr", d_addr, 0);
    chk("reset_wr", d_wr, 0);
    chk("reset_word", d_word, 0);
    chk("reset_tag", d_tag, 0);
    chk("reset_sweep_busy", s_busy, 0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    s_rst_n = 1'b1;

    // Vector table
    for (int n = 0; n < 15; n++) begin
      step(vt[n].miss, vt[n].maddr, vt[n].spur, 1'b0, 1'b0);
      chk($sformatf("vec%0d_busy", n), d_busy, vt[n].busy);
      chk($sformatf("vec%0d_mem_en", n), d_en, vt[n].en);
      chk($sformatf("vec%0d_addr", n), d_addr, vt[n].addr);
      chk($sformatf("vec%0d_wr", n), d_wr, vt[n].wr);
      chk($sformatf("vec%0d_tag", n), d_tag, vt[n].tag);
      if (vt[n].wr) chk($sformatf("vec%0d_word", n), d_word, vt[n].word);
    end

    // Back-to-back: 0x00F0 presented in the first idle cycle after a 0x1234 fill.
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < DW + DL; n++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h00F0, 1'b0, 1'b0, 1'b1);
    chk("b2b_idle_gap", d_busy, 0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", d_busy, 1);
    chk("b2b_addr", d_addr, 16'h00F0);
    for (int n = 0; n < DW + DL; n++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Reset mid-fill at cycle 6; in-flight returns afterwards must be ignored.
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("midrst_busy", d_busy, 0);
    chk("midrst_wr", d_wr, 0);
    chk("midrst_tag", d_tag, 0);
    for (int n = 7; n <= 14; n++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Randomized misses, addresses and idle-time spurious returns.
    for (int n = 0; n < 400; n++) begin
      bit rm, rs;
      rm = ($urandom_range(0, 7) == 0);
      rs = !m_busy(cyc + 1) && ($urandom_range(0, 3) == 0);
      step(rm, 16'($urandom), rs, 1'b0, 1'b1);
    end
    for (int n = 0; n < DW + DL + 1; n++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Parameter sweep: miss at 0xFFF4, block base 0xFFF0, latency-1 memory.
    @(negedge clk);
    s_miss  = 1'b1;
    s_maddr = 16'hFFF4;
    #1;
    chk("sweep_idle", s_busy, 0);
    prev_en = 1'b0;
    prev_a  = '0;
    nb = 0; na = 0; nw = 0; nt = 0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      s_miss  = 1'b0;
      s_valid = prev_en;
      s_data  = data32(prev_a);
      #1;
      if (s_busy) nb++;
      if (s_en) begin
        chk($sformatf("sweep_addr%0d", na), s_addr, 16'(16'hFFF0 + na * 4));
        na++;
      end else begin
        chk($sformatf("sweep_addr_zero_t%0d", t), s_addr, 0);
      end
      if (s_wr) begin
        chk($sformatf("sweep_word%0d", nw), s_word, nw);
        chk($sformatf("sweep_data%0d", nw), s_fdata, data32(16'(16'hFFF0 + nw * 4)));
        nw++;
      end
      if (s_tag) begin
        nt++;
        chk("sweep_tag_cycle", t, 5);
      end
      prev_en = s_en;
      prev_a  = s_addr;
    end
    chk("sweep_busy_cycles", nb, 5);
    chk("sweep_requests", na, 4);
    chk("sweep_writes", nw, 4);
    chk("sweep_tags", nt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Parametrised cache-miss fill engine for the Phase 3 pipelined CPU: it replaces the single-cycle, always-ready memory path with a block refill from a multi-cycle, pipelined main memory. On a miss from the I- or D-cache it issues one word read per cycle for the whole block. It steers the returning words into the cache data array, then writes the tag. Two instances are used, one per cache, and both share one memory arbiter upstream.

## Interface
Parameters:
- ADDR_W, 16, address width in bits (byte addresses)
- DATA_W, 16, memory word width; must be a multiple of 8
- WORDS_PER_BLOCK, 8, words per cache block; must be a power of 2 and ≥2
- MEM_LATENCY, 4, cycles from a request to its `memory_data_valid`; must be ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_detected  in  1  cache miss this cycle (level)
- miss_address  in  ADDR_W  byte address that missed
- memory_data_valid  in  1  memory return strobe
- memory_data  in  DATA_W  returned word
- fsm_busy  out  1  fill in progress; the pipeline stalls on this
- mem_en  out  1  read request this cycle
- memory_address  out  ADDR_W  request address; 0 when `mem_en`=0
- write_data_array  out  1  write `fill_data` into word `fill_word`
- fill_word  out  $clog2(WORDS_PER_BLOCK)  word index inside the block
- fill_data  out  DATA_W  equals `memory_data`
- write_tag_array  out  1  one-cycle pulse that writes the tag and valid bit

## Operation
- **Derived constants:**
  - BYTES = DATA_W/8
  - OFF_W = $clog2(WORDS_PER_BLOCK*BYTES)
- **States:** IDLE and FILL.
- **IDLE → FILL:** taken when `miss_detected`=1.
  - Latch `base` = `miss_address` with bits [OFF_W-1:0] cleared.
  - Clear `issue_cnt` and `recv_cnt`.
- **In FILL, issue side:**
  - While `issue_cnt` < WORDS_PER_BLOCK: `mem_en`=1 and `memory_address` = `base` + `issue_cnt`*BYTES.
  - `issue_cnt` increments each cycle and stops at WORDS_PER_BLOCK.
- **In FILL, receive side:**
  - On `memory_data_valid`: `write_data_array`=1 and `fill_word`=`recv_cnt`.
  - `recv_cnt` then increments.
- **Completion:** the receive of word WORDS_PER_BLOCK-1 also asserts `write_tag_array`=1 in the same cycle. Next state is IDLE.
- **Ignored inputs:**
  - `miss_detected` while in FILL.
  - `memory_data_valid` in IDLE, or after the last word has been received.
- **Addressing:** `base` is block-aligned, so the address adder never wraps inside a block. All arithmetic is modulo 2^ADDR_W.
- **Back-to-back misses:** a new miss presented in the first IDLE cycle after a fill is accepted immediately.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, and both counters are 0.
- **Reset mid-fill:** returns to IDLE at once with no tag write. Memory returns still in flight after reset are ignored.
- **Fill timeline** (miss accepted at cycle 0, W = WORDS_PER_BLOCK, L = MEM_LATENCY):
  - FILL occupies cycles 1 … W+L.
  - Requests are issued in cycles 1 … W.
  - Word k is written at cycle 1+k+L.
  - `write_tag_array` pulses at cycle W+L.
  - `fsm_busy` is 0 again at cycle W+L+1.
- **Worked example:** with the defaults, `fsm_busy` is high for exactly 12 cycles.
- **Output timing:**
  - `fsm_busy`, `mem_en` and `memory_address` are functions of registered state only.
  - `write_data_array`, `write_tag_array` and `fill_data` are combinational from `memory_data_valid`.

## Structure
- **Shared package `cache_pkg`:**
  - state enum {IDLE, FILL}
  - default parameter constants
  - the BYTES and OFF_W derivation functions
- **Sub-module `fill_counter`:**
  - Parametrised width, with synchronous clear, increment enable and a saturate-at-limit flag.
  - Instantiated twice, for `issue_cnt` and `recv_cnt`.

## Test plan
- **Basic fill (defaults):** `miss_address`=0x1234.
  - `mem_en` is high for 8 cycles with addresses 0x1230, 0x1232 … 0x123E.
  - `fill_word` steps 0…7 on the returning data.
  - `write_tag_array` pulses once at cycle 12; `fsm_busy` is high for 12 cycles.
- **Ignored inputs:**
  - A second `miss_detected` pulse at cycle 3 has no effect.
  - A spurious `memory_data_valid` in IDLE produces no `write_data_array`.
- **Back-to-back misses:** 0x1234, then 0x00F0 presented in the first IDLE cycle.
  - The second fill starts the next cycle with base 0x00F0.
- **Reset mid-fill:** assert `rst_n`=0 at cycle 6.
  - All outputs go to 0 immediately and there is no tag write.
  - Late returns at cycles 7–12 are ignored.
- **Parameter sweep:** WORDS_PER_BLOCK=4, MEM_LATENCY=1, DATA_W=32, `miss_address`=0xFFF4.
  - Base is 0xFFF0; addresses are 0xFFF0, 0xFFF4, 0xFFF8, 0xFFFC.
  - `fsm_busy` is high for 5 cycles.
